// File: rtl/pwm_fade_sequencer.sv
// Breathing-fade duty sequencer for three RGB PWM channels, stepped on a divided tick.
// Latency: lvl moves on tick clks, duties follow one clk later; cfg_ready stays low while a config is pending.
module pwm_fade_sequencer #(
    parameter int R        = 8,
    parameter int TICK_DIV = 2499999,
    parameter int DEF_STEP = 1,
    parameter int DEF_HOLD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic [1:0]   ch_sel,
    input  logic         cfg_valid,
    input  logic [R-1:0] cfg_step,
    input  logic [7:0]   cfg_hold,
    output logic         cfg_ready,
    output logic [R:0]   duty_r,
    output logic [R:0]   duty_g,
    output logic [R:0]   duty_b,
    output logic [2:0]   state_o,
    output logic         cycle_done
);
    localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [R:0]   FULL_L = {1'b1, {R{1'b0}}};
    localparam logic [R+1:0] FULL_W = {1'b0, FULL_L};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [R:0]      lvl_q, lvl_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [1:0]      chan_q, chan_d;
    logic [1:0]      mode_q, mode_d;
    logic [R-1:0]    step_q, step_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic            pend_vld_q, pend_vld_d;
    logic [R-1:0]    pend_step_q, pend_step_d;
    logic [7:0]      pend_hold_q, pend_hold_d;
    logic [R:0]      duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
    logic            cycle_done_q, cycle_done_d;

    logic            tick, go_idle, apply;
    logic [R+1:0]    sum;
    logic [1:0]      sel;
    logic [2:0]      on;

    assign tick    = (tick_cnt_q == TW'(TICK_DIV));
    assign go_idle = !en || (mode == 2'b00);
    // Widened by one bit so the ramp can overshoot full scale before saturating.
    assign sum     = {1'b0, lvl_q} + {2'b00, step_q};

    always_comb begin
        state_d      = state_q;
        lvl_d        = lvl_q;
        tick_cnt_d   = tick_cnt_q;
        chan_d       = chan_q;
        mode_d       = mode_q;
        step_d       = step_q;
        hold_d       = hold_q;
        hold_cnt_d   = hold_cnt_q;
        pend_vld_d   = pend_vld_q;
        pend_step_d  = pend_step_q;
        pend_hold_d  = pend_hold_q;
        cycle_done_d = 1'b0;
        apply        = 1'b0;

        if (state_q != IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        end

        if (go_idle) begin
            state_d    = IDLE;
            lvl_d      = '0;
            hold_cnt_d = '0;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = UP;
                    lvl_d      = '0;
                    hold_cnt_d = '0;
                    tick_cnt_d = '0;
                    chan_d     = 2'd0;
                    mode_d     = mode;
                    apply      = 1'b1;
                end
                UP: if (tick) begin
                    if (sum >= FULL_W) begin
                        lvl_d   = FULL_L;
                        state_d = HOLD_HI;
                    end else begin
                        lvl_d = sum[R:0];
                    end
                end
                HOLD_HI: if (tick) begin
                    if (hold_cnt_q == hold_q) begin
                        state_d    = DOWN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                DOWN: if (tick) begin
                    if (lvl_q <= {1'b0, step_q}) begin
                        lvl_d   = '0;
                        state_d = HOLD_LO;
                    end else begin
                        lvl_d = lvl_q - {1'b0, step_q};
                    end
                end
                HOLD_LO: if (tick) begin
                    if (hold_cnt_q == hold_q) begin
                        state_d      = UP;
                        hold_cnt_d   = '0;
                        cycle_done_d = 1'b1;
                        apply        = 1'b1;
                        mode_d       = mode;
                        if (mode_q == 2'b10) begin
                            chan_d = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (apply && pend_vld_q) begin
            step_d     = pend_step_q;
            hold_d     = pend_hold_q;
            pend_vld_d = 1'b0;
        end
        // Accept only into an empty slot, so a same-clk apply always consumes the older entry.
        if (cfg_valid && !pend_vld_q) begin
            pend_vld_d  = 1'b1;
            pend_step_d = (cfg_step == '0) ? R'(1) : cfg_step;
            pend_hold_d = cfg_hold;
        end
    end

    always_comb begin
        sel = 2'd0;
        on  = 3'b000;
        case (mode_q)
            2'b01: begin
                sel = (ch_sel == 2'd3) ? 2'd0 : ch_sel;
                on  = 3'b001 << sel;
            end
            2'b10:   on = 3'b001 << chan_q;
            2'b11:   on = 3'b111;
            default: on = 3'b000;
        endcase
        duty_r_d = (on[0] && !go_idle) ? lvl_q : '0;
        duty_g_d = (on[1] && !go_idle) ? lvl_q : '0;
        duty_b_d = (on[2] && !go_idle) ? lvl_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lvl_q        <= '0;
            tick_cnt_q   <= '0;
            chan_q       <= 2'd0;
            mode_q       <= 2'b00;
            step_q       <= R'(DEF_STEP);
            hold_q       <= 8'(DEF_HOLD);
            hold_cnt_q   <= '0;
            pend_vld_q   <= 1'b0;
            pend_step_q  <= '0;
            pend_hold_q  <= '0;
            duty_r_q     <= '0;
            duty_g_q     <= '0;
            duty_b_q     <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            tick_cnt_q   <= tick_cnt_d;
            chan_q       <= chan_d;
            mode_q       <= mode_d;
            step_q       <= step_d;
            hold_q       <= hold_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_step_q  <= pend_step_d;
            pend_hold_q  <= pend_hold_d;
            duty_r_q     <= duty_r_d;
            duty_g_q     <= duty_g_d;
            duty_b_q     <= duty_b_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign cfg_ready  = !pend_vld_q;
    assign duty_r     = duty_r_q;
    assign duty_g     = duty_g_q;
    assign duty_b     = duty_b_q;
    assign state_o    = state_q;
    assign cycle_done = cycle_done_q;
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed tick tables, corner sequences and randomized fades vs a per-tick ramp model.
module tb_pwm_fade_sequencer;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst, en, cfg_valid;
    logic [1:0]   mode, ch_sel;
    logic [R-1:0] cfg_step;
    logic [7:0]   cfg_hold;
    logic         cfg_ready, cycle_done;
    logic [R:0]   duty_r, duty_g, duty_b;
    logic [2:0]   state_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int st;
        int lvl;
        int done;
        int chan;
    } tick_t;

    typedef struct {
        int step;
        int st;
        int lvl;
        int done;
    } vec_t;

    tick_t exp_q[$];
    vec_t  tbl[18];

    pwm_fade_sequencer #(.R(R), .TICK_DIV(3), .DEF_STEP(1), .DEF_HOLD(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ch_sel(ch_sel),
        .cfg_valid(cfg_valid), .cfg_step(cfg_step), .cfg_hold(cfg_hold),
        .cfg_ready(cfg_ready), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .state_o(state_o), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic tick_t mk(input int st, input int lvl, input int done, input int chan);
        tick_t t;
        t.st = st; t.lvl = lvl; t.done = done; t.chan = chan;
        return t;
    endfunction

    // One full breathing cycle as a list of (state, level) after each tick.
    task automatic push_cycle(input int s_in, input int h, input int chan);
        int v;
        int s;
        s = (s_in == 0) ? 1 : s_in;
        v = 0;
        do begin
            v = (v + s > 256) ? 256 : v + s;
            exp_q.push_back(mk((v == 256) ? 2 : 1, v, 0, chan));
        end while (v != 256);
        for (int i = 0; i < h; i++) exp_q.push_back(mk(2, 256, 0, chan));
        exp_q.push_back(mk(3, 256, 0, chan));
        do begin
            v = (v > s) ? v - s : 0;
            exp_q.push_back(mk((v == 0) ? 4 : 3, v, 0, chan));
        end while (v != 0);
        for (int i = 0; i < h; i++) exp_q.push_back(mk(4, 0, 0, chan));
        exp_q.push_back(mk(1, 0, 1, chan));
    endtask

    function automatic int exp_duty(input int md, input int cs, input int chan, input int lvl, input int idx);
        int c;
        if (md == 3) return lvl;
        c = (md == 1) ? ((cs == 3) ? 0 : cs) : chan;
        return (c == idx) ? lvl : 0;
    endfunction

    // Entered at a negedge; first_wait negedges later is the clk right after a tick edge.
    task automatic run_ticks(input int md, input int cs, input int first_wait, input int nmax, input int rdy_mode);
        int w;
        int n;
        int seen_done;
        tick_t t;
        w = first_wait;
        n = 0;
        seen_done = 0;
        while (exp_q.size() > 0 && n < nmax) begin
            t = exp_q.pop_front();
            repeat (w) @(negedge clk);
            chk("state", 32'(state_o), t.st);
            chk("cycle_done", 32'(cycle_done), t.done);
            if (rdy_mode == 1 && seen_done == 0) begin
                chk("cfg_ready_pending", 32'(cfg_ready), t.done);
                if (t.done != 0) begin
                    cfg_valid = 1'b0;
                    seen_done = 1;
                end
            end
            @(negedge clk);
            chk("duty_r", 32'(duty_r), exp_duty(md, cs, t.chan, t.lvl, 0));
            chk("duty_g", 32'(duty_g), exp_duty(md, cs, t.chan, t.lvl, 1));
            chk("duty_b", 32'(duty_b), exp_duty(md, cs, t.chan, t.lvl, 2));
            chk("done_width", 32'(cycle_done), 0);
            w = 3;
            n++;
        end
    endtask

    task automatic offer(input int s, input int h);
        int k;
        cfg_valid = 1'b1;
        cfg_step  = 8'(s);
        cfg_hold  = 8'(h);
        k = 0;
        while (cfg_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("cfg_accept_wait", k, (k < 20) ? k : 19);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_ready_after_accept", 32'(cfg_ready), 0);
    endtask

    task automatic restart(input int md, input int cs, input int s, input int h, input int do_cfg);
        en = 1'b0;
        repeat (2) @(negedge clk);
        if (do_cfg != 0) offer(s, h);
        mode   = 2'(md);
        ch_sel = 2'(cs);
        en     = 1'b1;
        @(negedge clk);
        chk("start_state", 32'(state_o), 1);
        chk("start_cfg_ready", 32'(cfg_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t_st[18]  = '{1, 1, 1, 2, 3, 3, 3, 3, 4, 1,  1, 1, 2, 3, 3, 3, 4, 1};
        int t_lvl[18] = '{64, 128, 192, 256, 256, 192, 128, 64, 0, 0,  100, 200, 256, 256, 156, 56, 0, 0};
        int t_dn[18]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1};
        int w;
        int md, cs, s, h, ncyc;
        for (int i = 0; i < 18; i++) begin
            tbl[i].step = (i < 10) ? 64 : 100;
            tbl[i].st   = t_st[i];
            tbl[i].lvl  = t_lvl[i];
            tbl[i].done = t_dn[i];
        end

        rst = 1'b0; en = 1'b0; mode = 2'b00; ch_sel = 2'd0;
        cfg_valid = 1'b0; cfg_step = '0; cfg_hold = '0;
        #12;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_duty_r", 32'(duty_r), 0);
        chk("rst_duty_g", 32'(duty_g), 0);
        chk("rst_duty_b", 32'(duty_b), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_cycle_done", 32'(cycle_done), 0);
        @(negedge clk);
        rst = 1'b1;

        // Default step after reset
        restart(3, 0, 0, 0, 0);
        push_cycle(1, 0, 0);
        run_ticks(3, 0, 4, 3, 0);
        exp_q.delete();

        // Table: step 64 and step 100, all channels together
        w = 4;
        for (int i = 0; i < 18; i++) begin
            if (i == 0 || tbl[i].step != tbl[i-1].step) begin
                restart(3, 0, tbl[i].step, 0, 1);
                w = 4;
            end
            exp_q.push_back(mk(tbl[i].st, tbl[i].lvl, tbl[i].done, 0));
            run_ticks(3, 0, w, 1, 0);
            w = 3;
        end

        // cfg_step=0 stored as 1
        restart(3, 0, 0, 0, 1);
        push_cycle(0, 0, 0);
        run_ticks(3, 0, 4, 2, 0);
        exp_q.delete();

        // Rotation R->G->B->R
        restart(2, 0, 128, 0, 1);
        push_cycle(128, 0, 0);
        push_cycle(128, 0, 1);
        push_cycle(128, 0, 2);
        push_cycle(128, 0, 0);
        run_ticks(2, 0, 4, 1000, 0);

        // Config offered mid-UP, second offer ignored while pending
        restart(3, 0, 64, 0, 1);
        cfg_valid = 1'b1; cfg_step = 8'd32; cfg_hold = 8'd2;
        @(negedge clk);
        chk("midup_cfg_ready", 32'(cfg_ready), 0);
        cfg_step = 8'd16; cfg_hold = 8'd1;
        push_cycle(64, 0, 0);
        push_cycle(32, 2, 0);
        run_ticks(3, 0, 3, 1000, 1);

        // en dropped during DOWN at lvl 128, then restart rotating from R
        restart(3, 0, 64, 0, 1);
        push_cycle(64, 0, 0);
        run_ticks(3, 0, 4, 7, 0);
        exp_q.delete();
        en = 1'b0;
        @(negedge clk);
        chk("endrop_state", 32'(state_o), 0);
        chk("endrop_duty_r", 32'(duty_r), 0);
        chk("endrop_duty_g", 32'(duty_g), 0);
        chk("endrop_duty_b", 32'(duty_b), 0);
        mode = 2'b10;
        en   = 1'b1;
        @(negedge clk);
        chk("reen_state", 32'(state_o), 1);
        push_cycle(64, 0, 0);
        run_ticks(2, 0, 4, 2, 0);
        exp_q.delete();

        // Async reset mid-HOLD_HI
        restart(3, 0, 64, 1, 1);
        push_cycle(64, 1, 0);
        run_ticks(3, 0, 4, 5, 0);
        exp_q.delete();
        #3 rst = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 0);
        chk("arst_duty_r", 32'(duty_r), 0);
        chk("arst_duty_g", 32'(duty_g), 0);
        chk("arst_duty_b", 32'(duty_b), 0);
        chk("arst_cfg_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_restart_state", 32'(state_o), 1);
        push_cycle(1, 0, 0);
        run_ticks(3, 0, 4, 3, 0);
        exp_q.delete();

        // Randomized fades against the ramp model
        for (int it = 0; it < 6; it++) begin
            md   = $urandom_range(1, 3);
            cs   = $urandom_range(0, 3);
            s    = $urandom_range(24, 255);
            h    = $urandom_range(0, 3);
            ncyc = (md == 2) ? 3 : 2;
            restart(md, cs, s, h, 1);
            for (int c = 0; c < ncyc; c++) push_cycle(s, h, (md == 2) ? (c % 3) : 0);
            run_ticks(md, cs, 4, 100000, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Controller that sequences duty values for the three RGB PWM channels: breathing fade (ramp up, hold, ramp down, hold) on a slow tick.
- Sits between board switches/config and three `pwm_enhanced` instances; drives their `duty` inputs only. Divisor and PWM generation stay outside.
- Replaces free-running duty counters with a bounded, saturating, handshake-configurable FSM.

Parameters:
- R, 8, PWM resolution; duty outputs are R+1 bits and full scale is 2**R.
- TICK_DIV, 2499999, fade tick period minus 1 in clk cycles (125 MHz / 50 Hz - 1).
- DEF_STEP, 1, step size after reset.
- DEF_HOLD, 0, hold length after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  enable; 0 forces IDLE
- mode  in  2  00 off, 01 single channel, 10 rotate R->G->B, 11 all channels together
- ch_sel  in  2  channel for mode 01: 0=R, 1=G, 2=B; 3 is treated as 0
- cfg_valid  in  1  new config offered
- cfg_step  in  R  level increment per tick; 0 is treated as 1
- cfg_hold  in  8  extra ticks spent in each hold state
- cfg_ready  out  1  config can be accepted
- duty_r  out  R+1  red duty
- duty_g  out  R+1  green duty
- duty_b  out  R+1  blue duty
- state_o  out  3  FSM state encoding: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4
- cycle_done  out  1  one-clk pulse at HOLD_LO->UP

Behaviour:
- Reset (rst=0, async):
  - state IDLE, lvl=0, tick counter 0, active channel R.
  - step_q=DEF_STEP, hold_q=DEF_HOLD, pending config empty.
  - cfg_ready=1; all duty outputs 0; cycle_done 0.
- Tick generator:
  - Counter runs 0..TICK_DIV and wraps to 0. `tick` is a 1-clk pulse on the wrap cycle.
  - Counter is held at 0 while the FSM is in IDLE.
- IDLE:
  - Exit to UP when en=1 and mode!=00. On exit: lvl=0, hold_cnt=0, active channel=R.
  - Any pending config is applied on that exit.
- en=0 or mode=00 in any state: next clk goes to IDLE, lvl=0, duties 0, pending config preserved.
- FSM transitions evaluate only on tick cycles; hold_cnt clears on every state change.
  - UP: lvl <= min(lvl+step_q, 2**R). In the same tick, if the new value equals 2**R, go to HOLD_HI.
  - HOLD_HI: if hold_cnt==hold_q go to DOWN, else hold_cnt++. hold_q=0 gives exactly one tick in HOLD_HI.
  - DOWN: lvl <= max(lvl-step_q, 0), saturating with no underflow wrap. If the new value equals 0, go to HOLD_LO.
  - HOLD_LO: same hold rule as HOLD_HI; on exit go to UP.
- Actions on HOLD_LO->UP exit:
  - cycle_done pulses.
  - Pending config is applied to step_q/hold_q.
  - In mode 10, active channel advances R->G->B->R.
  - The mode value is latched; mode changes between 01, 10 and 11 take effect only here or on IDLE exit.
- Arithmetic: lvl is R+1 bits. Sums are computed R+2 bits wide before saturation, so lvl never exceeds 2**R.
- Config handshake:
  - Transfer on cfg_valid&cfg_ready. cfg_step=0 is stored as 1.
  - After acceptance, cfg_ready=0 until the pending config is applied, then cfg_ready=1 the following clk.
  - A second offer while cfg_ready=0 is ignored; cfg_valid stays asserted by the source.
- Duty outputs are registered, one clk after the lvl update (two clks after tick).
  - mode 01: channel ch_sel gets lvl, others 0.
  - mode 10: active channel gets lvl, others 0.
  - mode 11: all three get lvl.
- Simultaneous events:
  - Tick and en falling together: IDLE wins.
  - Config accept and apply in the same clk: the newly accepted config is pending for the next cycle; the old pending value is applied.

Test Plan (TICK_DIV=3, R=8):
- Reset then en=1, mode=11, step=64 defaults via cfg -> duties 64,128,192,256 on successive ticks. Then HOLD_HI for 1 tick, 192,128,64,0, HOLD_LO for 1 tick, cycle_done pulse.
- step=100 -> UP saturates 100,200,256; DOWN 156,56,0 with no wrap to 0x1xx; state_o sequence 1,2,3,4 observed.
- mode=10, step=128, hold=0 -> duty_r active for cycle 1, duty_g for cycle 2, duty_b for cycle 3, duty_r for cycle 4. Inactive channels read 0 throughout.
- cfg offered mid-UP (step=32, hold=2) -> cfg_ready drops for one clk after accept and stays low. New step is used only after the next cycle_done; HOLD states then last 3 ticks; cfg_ready=1 the clk after apply.
- en dropped during DOWN with lvl=128 -> next clk state IDLE and all duties 0. Re-enable restarts at lvl 0 with channel R.
- Async rst asserted mid-HOLD_HI, not aligned to a clk edge -> outputs 0 immediately. step_q reverts to DEF_STEP: the first ramp uses +1 per tick.
